// File: rtl/char_row_writer.sv
// char_row_writer
//   Host-side write sequencer for the char_row text-row buffer. Decodes host
//   command bytes into character writes, cursor moves and full-row clears, and
//   steers the row buffer's x coordinate so each write is an address cycle
//   followed by a write cycle, both issued only while the display is blanked.
//
// Handshake: a byte is taken on the rising edge where host_valid and
//   host_ready are both high. host_ready is high only in IDLE (and never before
//   the first edge after reset release); host_data need not be held afterwards.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   vga_x, vga_y, blank VGA scan position and blanking flag
//   host_data/valid     command byte and its valid flag
//   host_ready          byte accepted this cycle if valid
//   row_xcoor/ycoor     coordinate bus to the row buffer (muxed x, pass-through y)
//   row_char, row_write character code and write strobe to the row buffer
//   cursor              current write column
//   busy                high whenever the FSM is not IDLE
//   dbg_state           current FSM state encoding, for observation
module char_row_writer #(
   parameter int         COLS       = 80,
   parameter logic [5:0] CLEAR_CODE = 6'h24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] vga_x,
   input  logic [8:0] vga_y,
   input  logic       blank,
   input  logic [7:0] host_data,
   input  logic       host_valid,
   output logic       host_ready,
   output logic [9:0] row_xcoor,
   output logic [8:0] row_ycoor,
   output logic [5:0] row_char,
   output logic       row_write,
   output logic [6:0] cursor,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BLANK,
      S_ADDR,
      S_WRITE,
      S_CLR_WAIT,
      S_CLR_ADDR,
      S_CLR_WRITE
   } state_t;

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);

   state_t     r_state;
   state_t     w_next;
   logic       r_ready_en;
   logic [6:0] r_cursor;
   logic [6:0] r_clr_col;
   logic [5:0] r_code;

   logic w_ready;
   logic w_accept;
   logic w_is_char;
   logic w_is_cur;
   logic w_cur_ok;
   logic w_is_clr;
   logic w_last_clr;

   // r_ready_en keeps host_ready low until the first edge after reset release.
   assign w_ready    = r_ready_en && (r_state == S_IDLE);
   assign w_accept   = host_valid && w_ready;
   assign w_is_char  = (host_data <= 8'h23);
   assign w_is_cur   = (host_data >= 8'h80) && (host_data <= 8'hCF);
   assign w_cur_ok   = ({1'b0, host_data[6:0]} < 8'(COLS));
   assign w_is_clr   = (host_data == 8'hFF);
   assign w_last_clr = (r_clr_col == LAST_COL);

   assign host_ready = w_ready;
   assign busy       = (r_state != S_IDLE);
   assign cursor     = r_cursor;
   assign row_ycoor  = vga_y;
   assign dbg_state  = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      row_xcoor = vga_x;
      row_write = 1'b0;
      row_char  = r_code;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_is_char) begin
                  w_next = S_WAIT_BLANK;
               end else if (w_is_clr) begin
                  w_next = S_CLR_WAIT;
               end
            end
         end
         S_WAIT_BLANK: begin
            if (blank) w_next = S_ADDR;
         end
         S_ADDR: begin
            row_xcoor = {r_cursor, 3'b000};
            w_next    = S_WRITE;
         end
         S_WRITE: begin
            row_xcoor = {r_cursor, 3'b000};
            row_write = 1'b1;
            w_next    = S_IDLE;
         end
         S_CLR_WAIT: begin
            // blank is re-checked before every column of the clear.
            if (blank) w_next = S_CLR_ADDR;
         end
         S_CLR_ADDR: begin
            row_xcoor = {r_clr_col, 3'b000};
            row_char  = CLEAR_CODE;
            w_next    = S_CLR_WRITE;
         end
         S_CLR_WRITE: begin
            row_xcoor = {r_clr_col, 3'b000};
            row_char  = CLEAR_CODE;
            row_write = 1'b1;
            w_next    = w_last_clr ? S_IDLE : S_CLR_WAIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath registers. Bytes are only accepted in IDLE, so the accept and
   // write-completion updates never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_en <= 1'b0;
         r_cursor   <= '0;
         r_clr_col  <= '0;
         r_code     <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_accept) begin
            if (w_is_char) r_code <= host_data[5:0];
            // Cursor values past the last column are dropped silently.
            if (w_is_cur && w_cur_ok) r_cursor <= host_data[6:0];
            if (w_is_clr) r_clr_col <= '0;
         end
         if (r_state == S_WRITE) begin
            r_cursor <= (r_cursor == LAST_COL) ? 7'd0 : r_cursor + 7'd1;
         end
         if (r_state == S_CLR_WRITE) begin
            r_clr_col <= r_clr_col + 7'd1;
            if (w_last_clr) r_cursor <= '0;
         end
      end
   end

endmodule

// File: tb/tb_char_row_writer.sv
module tb_char_row_writer;

  logic       clk;
  logic       rst_n;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic       blank;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic [9:0] row_xcoor;
  logic [8:0] row_ycoor;
  logic [5:0] row_char;
  logic       row_write;
  logic [6:0] cursor;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  logic [15:0] exp_q[$];     // expected writes: {row_xcoor, row_char}
  logic [5:0]  row_mem[80];  // downstream row model
  logic        prev_write = 1'b0;
  logic [9:0]  prev_x     = '0;

  char_row_writer #(.COLS(80), .CLEAR_CODE(6'h24)) dut (
    .clk(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y), .blank(blank),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .row_xcoor(row_xcoor), .row_ycoor(row_ycoor), .row_char(row_char),
    .row_write(row_write), .cursor(cursor), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard: every observed write must match the head of exp_q and be
  // preceded by an address cycle carrying the same x coordinate
  always @(negedge clk) begin
    if (row_write === 1'b1) begin
      logic [15:0] e;
      n_writes++;
      row_mem[row_xcoor[9:3]] = row_char;
      n_checks++;
      if (prev_write !== 1'b0 || prev_x !== row_xcoor)
        $display("FAIL strobe_protocol: prev_write=%0b prev_x=%0d x=%0d, need prev_write=0 prev_x=x",
                 prev_write, prev_x, row_xcoor);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: x=%0d char=%0h, none expected", row_xcoor, row_char);
      end else begin
        e = exp_q.pop_front();
        if ({row_xcoor, row_char} !== e)
          $display("FAIL write_data: got x=%0d char=%0h, need x=%0d char=%0h",
                   row_xcoor, row_char, e[15:6], e[5:0]);
        else n_pass++;
      end
    end
    prev_write = row_write;
    prev_x     = row_xcoor;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (host_ready !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (host_ready !== 1'b1) $display("FAIL send_timeout: host_ready=%0b, need 1", host_ready);
    else n_pass++;
    host_data  = b;
    host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    host_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%0b, need 0", busy);
    else n_pass++;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; blank = 1'b0; vga_x = 10'd123; vga_y = 9'd45;
    host_data = 8'h00; host_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({host_ready, row_write, busy} !== 3'b000)
      $display("FAIL reset_flags: ready/write/busy=%b, need 000", {host_ready, row_write, busy});
    else n_pass++;
    n_checks++;
    if (row_char !== 6'd0 || cursor !== 7'd0)
      $display("FAIL reset_regs: char=%0d cursor=%0d, need 0 0", row_char, cursor);
    else n_pass++;
    n_checks++;
    if (row_xcoor !== 10'd123 || row_ycoor !== 9'd45)
      $display("FAIL reset_coords: x=%0d y=%0d, need 123 45", row_xcoor, row_ycoor);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (host_ready !== 1'b0) $display("FAIL ready_before_edge: got %0b, need 0", host_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (host_ready !== 1'b1) $display("FAIL ready_after_edge: got %0b, need 1", host_ready);
    else n_pass++;
  endtask

  task automatic test_basic_write();
    blank = 1'b1; vga_x = 10'd300;
    exp_q.push_back({10'd0, 6'd5});
    send_byte(8'h05);
    n_checks++;
    if (busy !== 1'b1 || host_ready !== 1'b0 || row_xcoor !== 10'd300)
      $display("FAIL wait_blank_cycle: busy=%0b ready=%0b x=%0d, need 1 0 300", busy, host_ready, row_xcoor);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_xcoor !== 10'd0 || row_write !== 1'b0)
      $display("FAIL addr_cycle: x=%0d write=%0b, need 0 0", row_xcoor, row_write);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (row_write !== 1'b1 || row_char !== 6'd5 || row_xcoor !== 10'd0)
      $display("FAIL write_cycle: write=%0b char=%0d x=%0d, need 1 5 0", row_write, row_char, row_xcoor);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cursor !== 7'd1 || host_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL after_write: cursor=%0d ready=%0b busy=%0b, need 1 1 0", cursor, host_ready, busy);
    else n_pass++;
    n_checks++;
    if (row_mem[0] !== 6'd5) $display("FAIL row_model_col0: got %0d, need 5", row_mem[0]);
    else n_pass++;
  endtask

  task automatic test_cursor_wrap();
    send_byte(8'hCF);
    n_checks++;
    if (cursor !== 7'd79 || host_ready !== 1'b1)
      $display("FAIL cursor_set: cursor=%0d ready=%0b, need 79 1", cursor, host_ready);
    else n_pass++;
    exp_q.push_back({10'd632, 6'h0A});
    send_byte(8'h0A);
    wait_idle();
    n_checks++;
    if (cursor !== 7'd0) $display("FAIL cursor_wrap: got %0d, need 0", cursor);
    else n_pass++;
    exp_q.push_back({10'd0, 6'h0B});
    send_byte(8'h0B);
    wait_idle();
    n_checks++;
    if (cursor !== 7'd1) $display("FAIL cursor_after_wrap: got %0d, need 1", cursor);
    else n_pass++;
  endtask

  task automatic test_ignored();
    logic [7:0] bytes[4] = '{8'hD5, 8'h40, 8'h24, 8'hD0};
    int w0 = n_writes;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      n_checks++;
      if (cursor !== 7'd1 || busy !== 1'b0 || host_ready !== 1'b1)
        $display("FAIL ignored_%0h: cursor=%0d busy=%0b ready=%0b, need 1 0 1",
                 bytes[i], cursor, busy, host_ready);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_writes !== w0) $display("FAIL ignored_no_write: writes=%0d, need %0d", n_writes, w0);
    else n_pass++;
  endtask

  task automatic test_blank_gating();
    logic [9:0] xv;
    blank = 1'b0;
    exp_q.push_back({10'd8, 6'd7});
    send_byte(8'h07);
    for (int i = 0; i < 3; i++) begin
      xv = 10'(100 + i * 37);
      vga_x = xv;
      #1;
      n_checks++;
      if (busy !== 1'b1 || host_ready !== 1'b0 || row_write !== 1'b0 || row_xcoor !== xv)
        $display("FAIL gated_%0d: busy=%0b ready=%0b write=%0b x=%0d, need 1 0 0 %0d",
                 i, busy, host_ready, row_write, row_xcoor, xv);
      else n_pass++;
      @(negedge clk);
    end
    blank = 1'b1;
    @(negedge clk);
    n_checks++;
    if (row_xcoor !== 10'd8 || row_write !== 1'b0)
      $display("FAIL gated_addr: x=%0d write=%0b, need 8 0", row_xcoor, row_write);
    else n_pass++;
    blank = 1'b0;  // falls mid-pair: the write must still happen
    @(negedge clk);
    n_checks++;
    if (row_write !== 1'b1 || row_char !== 6'd7 || row_xcoor !== 10'd8)
      $display("FAIL gated_write: write=%0b char=%0d x=%0d, need 1 7 8", row_write, row_char, row_xcoor);
    else n_pass++;
    wait_idle();
    n_checks++;
    if (cursor !== 7'd2) $display("FAIL gated_cursor: got %0d, need 2", cursor);
    else n_pass++;
    blank = 1'b1;
  endtask

  task automatic test_clear();
    int w0 = n_writes;
    int cnt = 0;
    int bad = 0;
    for (int i = 0; i < 80; i++) exp_q.push_back({10'(i * 8), 6'h24});
    send_byte(8'hFF);
    while (busy === 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt !== 240) $display("FAIL clear_duration: busy cycles=%0d, need 240", cnt);
    else n_pass++;
    n_checks++;
    if (n_writes - w0 !== 80) $display("FAIL clear_count: writes=%0d, need 80", n_writes - w0);
    else n_pass++;
    n_checks++;
    if (cursor !== 7'd0) $display("FAIL clear_cursor: got %0d, need 0", cursor);
    else n_pass++;
    for (int i = 0; i < 80; i++) if (row_mem[i] !== 6'h24) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL clear_row_model: %0d columns differ, need 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({10'd0, 6'h00});
    exp_q.push_back({10'd8, 6'h23});
    send_byte(8'h00);
    send_byte(8'h23);
    wait_idle();
    n_checks++;
    if (cursor !== 7'd2 || row_mem[1] !== 6'h23)
      $display("FAIL back_to_back: cursor=%0d col1=%0h, need 2 23", cursor, row_mem[1]);
    else n_pass++;
  endtask

  task automatic test_reset_during_clear();
    int w0 = n_writes;
    int seen = 0;
    int t = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back({10'(i * 8), 6'h24});
    send_byte(8'hFF);
    while (seen < 10 && t < 100) begin
      @(negedge clk);
      t++;
      if (row_write === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 10) $display("FAIL rst_clear_progress: writes=%0d, need 10", seen);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (row_write !== 1'b0 || busy !== 1'b0 || cursor !== 7'd0 || host_ready !== 1'b0)
      $display("FAIL rst_mid_clear: write=%0b busy=%0b cursor=%0d ready=%0b, need 0 0 0 0",
               row_write, busy, cursor, host_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (host_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_release: ready=%0b busy=%0b, need 1 0", host_ready, busy);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_writes - w0 !== 10) $display("FAIL rst_abandon: writes=%0d, need 10", n_writes - w0);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 80; i++) row_mem[i] = '0;
    test_reset();
    test_basic_write();
    test_cursor_wrap();
    test_ignored();
    test_blank_gating();
    test_clear();
    test_back_to_back();
    test_reset_during_clear();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL missing_writes: %0d expected writes never seen", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/char_row_writer.md
# char_row_writer

Host-side write sequencer that sits directly upstream of the `char_row` text-row buffer. It accepts byte commands from the host interface over a valid/ready handshake and decodes them into character writes, cursor moves and row clears. It multiplexes the VGA coordinate bus into the row buffer so that each write runs its two-step "latch address, then write" sequence. All buffer accesses happen only during display blanking, so the active picture is never disturbed.

## Interface
Parameters:
- `COLS`, 80: columns per row; cursor range 0..COLS-1.
- `CLEAR_CODE`, 6'h24: character code written to every column by the clear command.

Ports:
- `clk`  in  1  system clock (pixel clock domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `vga_x`  in  10  current VGA x coordinate (0..639 active).
- `vga_y`  in  9  current VGA y coordinate.
- `blank`  in  1  high outside the active display area.
- `host_data`  in  8  command byte.
- `host_valid`  in  1  `host_data` is valid.
- `host_ready`  out  1  block accepts a byte this cycle.
- `row_xcoor`  out  10  x coordinate to the row buffer.
- `row_ycoor`  out  9  y coordinate to the row buffer; always equals `vga_y`.
- `row_char`  out  6  character code to the row buffer.
- `row_write`  out  1  write strobe to the row buffer.
- `cursor`  out  7  current write column.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Command decode**: a byte is accepted when `host_valid && host_ready`.
  - 0x00–0x23: write character code `host_data[5:0]` at `cursor`.
  - 0x80–0xCF: set `cursor = host_data[6:0]`. Only values 0..COLS-1 take effect; larger values are dropped and the cursor is unchanged.
  - 0xFF: clear the whole row.
  - All other bytes: accepted and discarded, with no state change.
- **FSM states**: IDLE, WAIT_BLANK, ADDR, WRITE, CLR_WAIT, CLR_ADDR, CLR_WRITE.
- **IDLE**
  - `host_ready = 1`.
  - On a character byte: latch the code and go to WAIT_BLANK.
  - On 0xFF: set `clr_col = 0` and go to CLR_WAIT.
  - On a cursor byte or an ignored byte: stay in IDLE.
- **WAIT_BLANK**: stay until `blank` is sampled high, then go to ADDR.
- **ADDR**: `row_xcoor = cursor << 3`, `row_write = 0`. The row buffer latches the address this cycle. Go to WRITE.
- **WRITE**
  - `row_xcoor` held at `cursor << 3`, `row_write = 1`, `row_char` = latched code.
  - Cursor advances: increments, wrapping from COLS-1 to 0.
  - Go to IDLE.
- **Clear sequence** (CLR_WAIT / CLR_ADDR / CLR_WRITE): same as WAIT_BLANK / ADDR / WRITE, but uses `clr_col` and `CLEAR_CODE`.
  - After each CLR_WRITE, `clr_col` increments.
  - If `clr_col` was COLS-1, the cursor is set to 0 and the FSM goes to IDLE.
  - Otherwise the FSM returns to CLR_WAIT, so `blank` is re-checked before every column.
- **Coordinate mux**: combinational.
  - `row_xcoor = vga_x` in every state except ADDR, WRITE, CLR_ADDR and CLR_WRITE.
  - `row_ycoor = vga_y` always.
- **`blank` dropping mid-write**: if `blank` falls during ADDR/WRITE (or the clear equivalents), the started pair still completes. A pair never aborts halfway.
- **Reset mid-operation**: asynchronous.
  - The FSM returns to IDLE and any pending write or clear is abandoned.
  - Row buffer contents are not touched by this block.

## Timing
- **Reset values**:
  - `row_write = 0`, `row_char = 0`, `cursor = 0`, `busy = 0`.
  - `host_ready = 0` while `rst_n` is low, and 1 from the first clock edge after release.
  - `row_xcoor` follows `vga_x`.
- **Handshake**:
  - `host_ready` is high only in IDLE.
  - The byte is accepted on the rising edge where valid and ready are both high.
  - `host_data` need not be held after acceptance.
- **Character-write latency** (byte accepted at edge T, `blank` already high):
  - WAIT_BLANK during T..T+1.
  - ADDR during T+1..T+2.
  - `row_write = 1` during T+2..T+3.
  - IDLE, ready and incremented cursor visible after T+3.
  - Maximum rate is one character per 4 cycles.
- **Cursor-set latency**: the new cursor is visible the cycle after acceptance and `host_ready` stays high.
- **Full-row clear**: takes at least 3·COLS = 240 cycles when `blank` stays high; `busy` is high throughout.
- **Write-strobe protocol**: `row_write` is high for exactly one cycle per write and is always preceded by one ADDR cycle carrying the same `row_xcoor`.

## Test plan
- **Basic write**: reset, hold `blank = 1`, send 0x05 → ADDR with `row_xcoor = 0`, then one `row_write` pulse with `row_char = 5`; `cursor = 1`; the downstream row model shows code 5 at column 0.
- **Cursor and wrap**: send 0xCF (cursor 79), then 0x0A, then 0x0B → writes at `row_xcoor` 632 then 0; final `cursor = 1`.
- **Out-of-range and ignored bytes**: send 0xD5, then 0x40 → both accepted, cursor unchanged, no `row_write`, `busy` stays 0.
- **Blank gating**: hold `blank = 0`, send 0x07 → `busy = 1`, `host_ready = 0`, `row_xcoor` tracks `vga_x`, no write; raise `blank` → write completes 2 cycles later.
- **Clear**: send 0xFF with `blank = 1` → exactly 80 `row_write` pulses, all with `row_char = 6'h24`, covering x = 0, 8, …, 632; then `cursor = 0`.
- **Reset during clear**: assert `rst_n = 0` after 10 clear writes → `row_write = 0` immediately, `busy = 0`, `cursor = 0`; `host_ready = 1` after release.
